// File: rtl/clkgen_pkg.sv
// -----------------------------------------------------------------------------
// clkgen_pkg
// Shared constants and helpers for the clock-enable generator.
//   DEF_DIV_W      default width of one channel's divide-ratio field
//   DEF_DEB_CYCLES default number of stable cycles to accept a button level
//   BTN_RELEASED   idle level of the active-low step pushbutton
//   eff_div()      effective divide ratio: ratios 0 and 1 both mean divide-by-1
// -----------------------------------------------------------------------------
package clkgen_pkg;

  localparam int unsigned DEF_DIV_W      = 8;
  localparam int unsigned DEF_DEB_CYCLES = 1000;
  localparam logic        BTN_RELEASED   = 1'b1;

  function automatic int unsigned eff_div(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

endpackage : clkgen_pkg

// File: rtl/step_debounce.sv
// -----------------------------------------------------------------------------
// step_debounce
// Two-flop synchroniser, debounce counter and falling-edge one-shot for the
// active-low step pushbutton.
// Ports:
//   clk_in     system clock
//   rst_n      asynchronous active-low reset
//   step       raw pushbutton level, asynchronous to clk_in
//   step_pulse one-cycle pulse per accepted press (debounced 1->0)
// -----------------------------------------------------------------------------
module step_debounce
  import clkgen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned DEB_W      = 10
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic step,
  output logic step_pulse
);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             deb_last_q;
  logic             pulse_q;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised level disagrees with the
  // accepted level; any agreement restarts the stability window.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= BTN_RELEASED;
      sync2_q    <= BTN_RELEASED;
      deb_q      <= BTN_RELEASED;
      deb_last_q <= BTN_RELEASED;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      sync1_q    <= step;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_last_q <= deb_q;
      cnt_q      <= cnt_d;
      // Press = debounced level falling; release produces nothing.
      pulse_q    <= deb_last_q & ~deb_q;
    end
  end

  assign step_pulse = pulse_q;

endmodule : step_debounce

// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
// NUM_CH programmable clock-enable channels with square-wave phase outputs and
// a run/single-step mode driven by a debounced pushbutton.
// Ports:
//   clk_in      system clock (all logic on this one clock)
//   rst_n       asynchronous active-low reset
//   div_ratio   channel i ratio at [i*DIV_W +: DIV_W]; 0 and 1 = divide-by-1
//   run_mode    1 = free-run, 0 = single-step
//   step        raw active-low pushbutton
//   ch_en       one-cycle enable per channel tick, after step gating
//   ch_phase    toggles on every raw tick (period 2*div)
//   step_pulse  one-cycle pulse per accepted press
//   step_count  (only with CLKGEN_STEP_CNT_EN) count of consumed step grants
// Optional feature macro: CLKGEN_STEP_CNT_EN
// -----------------------------------------------------------------------------
module clk_enable_gen
  import clkgen_pkg::*;
#(
  parameter int unsigned       NUM_CH     = 3,
  parameter int unsigned       DIV_W      = DEF_DIV_W,
  parameter int unsigned       DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned       DEB_W      = 10,
  parameter logic [NUM_CH-1:0] STEP_MASK  = NUM_CH'(3'b110),
  parameter int unsigned       STEP_REF   = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic                    run_mode,
  input  logic                    step,
  output logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ch_phase,
  output logic                    step_pulse
`ifdef CLKGEN_STEP_CNT_EN
  ,
  output logic [15:0]             step_count
`endif
);

  logic [NUM_CH-1:0] raw_tick;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d;
  logic [NUM_CH-1:0] ch_phase_q, ch_phase_d;
  logic              grant_q, grant_d;
  logic              ref_pass;
  logic              step_pulse_w;

  step_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_step_debounce (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .step       (step),
    .step_pulse (step_pulse_w)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d, per_q, cur_div;

    // The ratio is captured in the first cycle of each period and held in
    // per_q, so a mid-count change never shortens or stretches a period.
    assign cur_div     = (cnt_q == '0) ? DIV_W'(eff_div(32'(div_ratio[i*DIV_W +: DIV_W])))
                                       : per_q;
    assign raw_tick[i] = (cnt_q == cur_div - 1'b1);
    assign cnt_d       = raw_tick[i] ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        per_q <= DIV_W'(1);
      end else begin
        cnt_q <= cnt_d;
        per_q <= cur_div;
      end
    end
  end

  always_comb begin
    // Phase follows raw ticks in both modes so downstream phase stays aligned.
    ch_phase_d = ch_phase_q ^ raw_tick;
    ch_en_d    = raw_tick & (~STEP_MASK | {NUM_CH{run_mode | grant_q}});
    ref_pass   = grant_q & raw_tick[STEP_REF] & ~run_mode;
    // A press coincident with a reference tick only arms the next tick; a
    // press while armed is absorbed.
    grant_d    = grant_q;
    if (run_mode) begin
      grant_d = 1'b0;
    end else if (ref_pass) begin
      grant_d = 1'b0;
    end else if (step_pulse_w) begin
      grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ch_en_q    <= '0;
      ch_phase_q <= '0;
      grant_q    <= 1'b0;
    end else begin
      ch_en_q    <= ch_en_d;
      ch_phase_q <= ch_phase_d;
      grant_q    <= grant_d;
    end
  end

  assign ch_en      = ch_en_q;
  assign ch_phase   = ch_phase_q;
  assign step_pulse = step_pulse_w;

`ifdef CLKGEN_STEP_CNT_EN
  logic [15:0] step_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
    end else if (ref_pass) begin
      step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  assign step_count = step_cnt_q;
`endif

endmodule : clk_enable_gen

// File: tb/tb_clk_enable_gen.sv
module tb_clk_enable_gen;

  localparam int          NCH  = 3;
  localparam int          DW   = 8;
  localparam int          DEB  = 8;
  localparam logic [2:0]  MASK = 3'b110;
  localparam int          REF  = 2;

  logic            clk_in = 1'b0;
  logic            rst_n  = 1'b1;
  logic [NCH*DW-1:0] div_ratio = '0;
  logic            run_mode = 1'b1;
  logic            step     = 1'b1;
  logic [NCH-1:0]  ch_en;
  logic [NCH-1:0]  ch_phase;
  logic            step_pulse;
`ifdef CLKGEN_STEP_CNT_EN
  logic [15:0]     step_count;
`endif

  int errors = 0;
  int checks = 0;

  clk_enable_gen #(
    .NUM_CH     (NCH),
    .DIV_W      (DW),
    .DEB_CYCLES (DEB),
    .DEB_W      (4),
    .STEP_MASK  (MASK),
    .STEP_REF   (REF)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .div_ratio  (div_ratio),
    .run_mode   (run_mode),
    .step       (step),
    .ch_en      (ch_en),
    .ch_phase   (ch_phase),
    .step_pulse (step_pulse)
`ifdef CLKGEN_STEP_CNT_EN
    ,
    .step_count (step_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  // ---------------------------------------------------------------------------
  // Reference model: channels as a schedule of absolute tick times, the button
  // as a sliding window of sampled levels, grant as a simple flag.
  // ---------------------------------------------------------------------------
  longint      m_cyc;
  longint      m_start [NCH];
  longint      m_tick_at [NCH];
  logic [NCH-1:0] m_en, m_phase;
  logic        m_pulse, m_grant, m_deb, m_fell;
  logic [15:0] m_cnt;
  bit          hist[$];

  task automatic m_reset();
    m_cyc   = 0;
    for (int i = 0; i < NCH; i++) begin
      m_start[i]   = 0;
      m_tick_at[i] = -1;
    end
    m_en    = '0;
    m_phase = '0;
    m_pulse = 1'b0;
    m_grant = 1'b0;
    m_deb   = 1'b1;
    m_fell  = 1'b0;
    m_cnt   = '0;
    hist.delete();
    for (int k = 0; k < DEB + 2; k++) hist.push_back(1'b1);
  endtask

  // One rising edge, using the inputs presented during the preceding cycle.
  task automatic m_edge();
    logic [NCH-1:0] tick;
    logic old_pulse;
    bit   all_diff;
    int   d;
    old_pulse = m_pulse;
    for (int i = 0; i < NCH; i++) begin
      d = int'(div_ratio[i*DW +: DW]);
      if (d == 0) d = 1;
      if (m_cyc == m_start[i]) m_tick_at[i] = m_cyc + d - 1;
      tick[i] = (m_cyc == m_tick_at[i]);
      if (tick[i]) m_start[i] = m_cyc + 1;
    end
    // Synchroniser: the level seen now is the one sampled two edges ago;
    // accept it after DEB consecutive disagreeing samples.
    all_diff = 1'b1;
    for (int k = 0; k < DEB; k++)
      if (hist[hist.size() - 2 - k] == m_deb) all_diff = 1'b0;
    m_pulse = m_fell;
    m_fell  = 1'b0;
    if (all_diff) begin
      m_fell = m_deb;
      m_deb  = ~m_deb;
    end
    hist.push_back(step);
    void'(hist.pop_front());
    for (int i = 0; i < NCH; i++)
      m_en[i] = tick[i] & (run_mode | ~MASK[i] | m_grant);
    if (!run_mode && m_grant && tick[REF]) m_cnt = m_cnt + 16'd1;
    if (run_mode)                    m_grant = 1'b0;
    else if (m_grant && tick[REF])   m_grant = 1'b0;
    else if (old_pulse)              m_grant = 1'b1;
    m_phase = m_phase ^ tick;
    m_cyc++;
  endtask

  // Advance one clock and compare all outputs on the falling edge.
  task automatic cyc1();
    @(posedge clk_in);
    m_edge();
    @(negedge clk_in);
    checks++;
    if ({ch_en, ch_phase, step_pulse} !== {m_en, m_phase, m_pulse}) begin
      errors++;
      if (errors < 30)
        $display("FAIL cycle %0d outputs: got en=%b ph=%b sp=%b, expected en=%b ph=%b sp=%b",
                 m_cyc, ch_en, ch_phase, step_pulse, m_en, m_phase, m_pulse);
    end
`ifdef CLKGEN_STEP_CNT_EN
    checks++;
    if (step_count !== m_cnt) begin
      errors++;
      if (errors < 30)
        $display("FAIL cycle %0d step_count: got %0d, expected %0d", m_cyc, step_count, m_cnt);
    end
`endif
  endtask

  // Assert reset mid-cycle, check outputs clear asynchronously, release at a
  // falling edge with the button released.
  task automatic apply_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ch_en, ch_phase, step_pulse} !== '0) begin
      errors++;
      $display("FAIL %s async clear: got en=%b ph=%b sp=%b, expected all 0",
               tag, ch_en, ch_phase, step_pulse);
    end
`ifdef CLKGEN_STEP_CNT_EN
    checks++;
    if (step_count !== 16'd0) begin
      errors++;
      $display("FAIL %s step_count clear: got %0d, expected 0", tag, step_count);
    end
`endif
    step = 1'b1;
    @(negedge clk_in);
    rst_n = 1'b1;
    m_reset();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    run_mode  = 1'b1;
    step      = 1'b1;
    div_ratio = {8'd4, 8'd2, 8'd1};
    #3;
    apply_reset("reset");
  endtask

  task automatic test_free_run();
    int n0, n1, n2;
    n0 = 0; n1 = 0; n2 = 0;
    for (int c = 0; c < 40; c++) begin
      cyc1();
      n0 += int'(ch_en[0]);
      n1 += int'(ch_en[1]);
      n2 += int'(ch_en[2]);
    end
    checks++;
    if (n0 != 40 || n1 != 20 || n2 != 10) begin
      errors++;
      $display("FAIL free_run counts: got %0d/%0d/%0d, expected 40/20/10", n0, n1, n2);
    end
  endtask

  task automatic test_ratio_change();
    int pos[$];
    int exp_pos[$];
    // Move to the second cycle of a ch1 period (counter mid-count).
    for (int c = 0; c < 4 && m_en[1]; c++) cyc1();
    div_ratio[DW +: DW] = 8'd5;
    for (int c = 1; c <= 28; c++) begin
      cyc1();
      if (ch_en[1]) pos.push_back(c);
    end
    exp_pos = '{1, 6, 11, 16, 21, 26};
    checks++;
    if (pos != exp_pos) begin
      errors++;
      $display("FAIL ratio_change ch1 pulse positions: got %p, expected %p", pos, exp_pos);
    end
  endtask

  task automatic test_debounce();
    int np, at;
    np = 0;
    step = 1'b0;
    for (int c = 0; c < 5; c++) begin cyc1(); np += int'(step_pulse); end
    step = 1'b1;
    for (int c = 0; c < 30; c++) begin cyc1(); np += int'(step_pulse); end
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL debounce short bounce: got %0d pulses, expected 0", np);
    end
    np = 0; at = -1;
    step = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cyc1();
      if (step_pulse) begin np++; at = c; end
    end
    checks++;
    if (np != 1 || at != 2 + DEB + 1) begin
      errors++;
      $display("FAIL debounce press: got %0d pulses at %0d, expected 1 at %0d", np, at, 2 + DEB + 1);
    end
    np = 0;
    step = 1'b1;
    for (int c = 0; c < 20; c++) begin cyc1(); np += int'(step_pulse); end
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL debounce release: got %0d pulses, expected 0", np);
    end
  endtask

  task automatic test_step_mode();
    int n0, n1, n2;
    n0 = 0; n1 = 0; n2 = 0;
    run_mode = 1'b0;
    for (int c = 0; c < 100; c++) begin
      cyc1();
      n0 += int'(ch_en[0]);
      n1 += int'(ch_en[1]);
      n2 += int'(ch_en[2]);
    end
    checks++;
    if (n0 != 100 || n1 != 0 || n2 != 0) begin
      errors++;
      $display("FAIL step_mode idle counts: got %0d/%0d/%0d, expected 100/0/0", n0, n1, n2);
    end
    n2 = 0;
    step = 1'b0;
    for (int c = 0; c < 20; c++) begin cyc1(); n2 += int'(ch_en[2]); end
    step = 1'b1;
    for (int c = 0; c < 30; c++) begin cyc1(); n2 += int'(ch_en[2]); end
    checks++;
    if (n2 != 1) begin
      errors++;
      $display("FAIL step_mode single press: got %0d ch_en[2] pulses, expected 1", n2);
    end
  endtask

  // Sweep the press phase against the ch2 period so one press lands its
  // step_pulse on the same cycle as a reference tick.
  task automatic test_coincident();
    int n2;
    run_mode = 1'b0;
    for (int off = 0; off < 4; off++) begin
      n2 = 0;
      for (int c = 0; c < off; c++) cyc1();
      step = 1'b0;
      for (int c = 0; c < 20; c++) begin cyc1(); n2 += int'(ch_en[2]); end
      step = 1'b1;
      for (int c = 0; c < 30; c++) begin cyc1(); n2 += int'(ch_en[2]); end
      checks++;
      if (n2 != 1) begin
        errors++;
        $display("FAIL coincident offset %0d: got %0d ch_en[2] pulses, expected 1", off, n2);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        int ch;
        ch = int'($urandom_range(0, NCH - 1));
        div_ratio[ch*DW +: DW] = DW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 199) == 0) run_mode = ~run_mode;
      if (hold == 0) begin
        step = ~step;
        hold = int'($urandom_range(1, 20));
      end else begin
        hold--;
      end
      cyc1();
    end
  endtask

  task automatic test_reset_mid();
    int np, n2;
    run_mode  = 1'b0;
    div_ratio = {8'd60, 8'd2, 8'd1};
    apply_reset("pre_mid");
    step = 1'b0;
    for (int c = 0; c < 14; c++) cyc1();
    step = 1'b1;
    for (int c = 0; c < 12; c++) cyc1();
    step = 1'b0;
    for (int c = 0; c < 5; c++) cyc1();
    apply_reset("reset_mid");
    np = 0; n2 = 0;
    for (int c = 0; c < 40; c++) begin
      cyc1();
      np += int'(step_pulse);
      n2 += int'(ch_en[2]);
    end
    checks++;
    if (np != 0 || n2 != 0) begin
      errors++;
      $display("FAIL reset_mid after release: got %0d step_pulse / %0d ch_en[2], expected 0/0", np, n2);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_free_run();
    test_ratio_change();
    test_debounce();
    test_step_mode();
    test_coincident();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_clk_enable_gen
